// File: rtl/m_decoder_kind_queue.sv
// Kind-classifying instruction queue: tags each instruction by its top nibble and buffers {instr, kind}.
// Build option DECODER_KIND_TRAP_EN: invalid-kind instructions are dropped and reported on trap.
package m_decoder_kind_queue_pkg;
    typedef enum logic [2:0] {
        KIND_RRR     = 3'd0,
        KIND_MEMORY  = 3'd1,
        KIND_MODEL   = 3'd2,
        KIND_RRI     = 3'd3,
        KIND_CUSTOM  = 3'd4,
        KIND_INVALID = 3'd7
    } e_kind;
endpackage

module m_decoder_kind_queue
    import m_decoder_kind_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output e_kind                    out_kind,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         inv_count,
    output logic                     trap
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [XLEN-1:0]  r_mem_instr [DEPTH];
    e_kind            r_mem_kind  [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [XLEN-1:0]  r_out_instr;
    e_kind            r_out_kind;
    logic [CNT_W-1:0] r_inv_count;

    logic [3:0]       w_nib;
    e_kind            w_kind;
    logic             w_push;
    logic             w_store;
    logic             w_pop;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic [LW-1:0]    w_level_nxt;
    logic [XLEN-1:0]  w_head_instr;
    e_kind            w_head_kind;

    assign w_nib = in_instr[XLEN-1 -: 4];

    always_comb begin
        w_kind = KIND_CUSTOM;
        casez (w_nib)
            4'b0000: w_kind = KIND_RRR;
            4'b0001: w_kind = KIND_MEMORY;
            4'b0010: w_kind = KIND_MODEL;
            4'b0011: w_kind = KIND_INVALID;
            4'b01??: w_kind = KIND_RRI;
            4'b10??: w_kind = KIND_INVALID;
            default: w_kind = KIND_CUSTOM;
        endcase
    end

    // No full-bypass: a pop in the same cycle does not reopen a full queue.
    assign in_ready  = (r_level != LVL_FULL) && !flush;
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !flush;

`ifdef DECODER_KIND_TRAP_EN
    logic r_trap;

    assign w_store = w_push && (w_kind != KIND_INVALID);
    assign trap    = r_trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap <= 1'b0;
        end else begin
            r_trap <= w_push && (w_kind == KIND_INVALID);
        end
    end
`else
    assign w_store = w_push;
    assign trap    = 1'b0;
`endif

    always_comb begin
        w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
        w_level_nxt  = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else if (w_store && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (!w_store && w_pop) begin
            w_level_nxt = r_level - LW'(1);
        end
        // The next head is the word being written now when it lands in the slot rd_ptr moves to.
        if (w_store && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_instr = in_instr;
            w_head_kind  = w_kind;
        end else begin
            w_head_instr = r_mem_instr[w_rd_ptr_nxt];
            w_head_kind  = r_mem_kind[w_rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_instr[r_wr_ptr] <= in_instr;
            r_mem_kind[r_wr_ptr]  <= w_kind;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_instr <= '0;
            r_out_kind  <= KIND_INVALID;
        end else begin
            r_level <= w_level_nxt;
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                r_rd_ptr <= w_rd_ptr_nxt;
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                // Output register holds its last value once the queue drains.
                if (w_level_nxt != '0) begin
                    r_out_instr <= w_head_instr;
                    r_out_kind  <= w_head_kind;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inv_count <= '0;
        end else if (w_push && (w_kind == KIND_INVALID) && (r_inv_count != '1)) begin
            r_inv_count <= r_inv_count + CNT_W'(1);
        end
    end

    assign out_instr = r_out_instr;
    assign out_kind  = r_out_kind;
    assign level     = r_level;
    assign inv_count = r_inv_count;

endmodule

// File: tb/tb_m_decoder_kind_queue.sv
// Scoreboard bench for m_decoder_kind_queue; follows DECODER_KIND_TRAP_EN when it is defined.
`timescale 1ns/1ps
module tb_m_decoder_kind_queue;
    import m_decoder_kind_queue_pkg::*;

`ifdef DECODER_KIND_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready, out_valid, trap;
    logic [31:0] out_instr;
    e_kind       out_kind;
    logic [2:0]  level;
    logic [15:0] inv_count;

    logic        in_valid2 = 1'b0;
    logic        out_ready2 = 1'b1;
    logic        in_ready2, out_valid2, trap2;
    logic [31:0] out_instr2;
    e_kind       out_kind2;
    logic [2:0]  level2;
    logic [1:0]  inv_count2;

    int n_cmp = 0;
    int n_err = 0;
    int trap_cnt = 0;
    logic [34:0] exp_q[$];

    m_decoder_kind_queue #(.XLEN(32), .DEPTH(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_kind(out_kind),
        .level(level), .inv_count(inv_count), .trap(trap)
    );

    m_decoder_kind_queue #(.XLEN(32), .DEPTH(4), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_kind(out_kind2),
        .level(level2), .inv_count(inv_count2), .trap(trap2)
    );

    always #5 clk = ~clk;

    function automatic e_kind model_kind(input logic [31:0] w);
        case (w[31:28])
            4'h0:                    return KIND_RRR;
            4'h1:                    return KIND_MEMORY;
            4'h2:                    return KIND_MODEL;
            4'h4, 4'h5, 4'h6, 4'h7:  return KIND_RRI;
            4'hC, 4'hD, 4'hE, 4'hF:  return KIND_CUSTOM;
            default:                 return KIND_INVALID;
        endcase
    endfunction

    // Scoreboard: pops compared against the queue, accepted pushes appended.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_unexpected: got %h/%0d, required no entry", out_instr, out_kind);
                end else begin
                    if ({out_instr, out_kind} !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL pop_data: got %h/%0d, required %h/%0d",
                                 out_instr, out_kind, exp_q[0][34:3], exp_q[0][2:0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready && !(TRAP_EN && (model_kind(in_instr) == KIND_INVALID)))
                exp_q.push_back({in_instr, model_kind(in_instr)});
        end
        if (trap) trap_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output bit ok);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d, required 0", level); end
        n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h, required 0", out_instr); end
        n_cmp++; if (out_kind !== KIND_INVALID) begin n_err++; $display("FAIL reset_out_kind: got %0d, required %0d", out_kind, KIND_INVALID); end
        n_cmp++; if (inv_count !== 16'd0) begin n_err++; $display("FAIL reset_inv_count: got %0d, required 0", inv_count); end
        n_cmp++; if (trap !== 1'b0) begin n_err++; $display("FAIL reset_trap: got %b, required 0", trap); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_kinds();
        logic [31:0] words [5] = '{32'h0000_0000, 32'h1fff_ffff, 32'h2fff_ffff, 32'h7fff_ffff, 32'hc000_0000};
        e_kind       kinds [5] = '{KIND_RRR, KIND_MEMORY, KIND_MODEL, KIND_RRI, KIND_CUSTOM};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = words[i];
            tick();
            n_cmp++;
            if (!out_valid || out_instr !== words[i] || out_kind !== kinds[i]) begin
                n_err++;
                $display("FAIL kind_latency[%0d]: got v=%b %h/%0d, required v=1 %h/%0d",
                         i, out_valid, out_instr, out_kind, words[i], kinds[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL kinds_empty_level: got %0d, required 0", level); end
        n_cmp++;
        if (out_instr !== 32'hc000_0000 || out_kind !== KIND_CUSTOM) begin
            n_err++;
            $display("FAIL empty_hold: got %h/%0d, required c0000000/%0d", out_instr, out_kind, KIND_CUSTOM);
        end
    endtask

    task automatic test_full();
        bit ok;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h4abc_0000 + 32'(i);
            tick();
        end
        in_instr = 32'h4abc_0004;
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d, required 4", level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
        tick();
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_hold_level: got %0d, required 4", level); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL no_bypass: got %b, required 0", in_ready); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL full_pop_level: got %0d, required 3", level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_reopen: got %b, required 1", in_ready); end
        tick();
        n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL fifth_accept: got %0d, required 4", level); end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL full_drain_timeout: got out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_wrap();
        logic [3:0] nibs [6] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'he};
        bit ok;
        out_ready = 1'b0;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_instr = {nibs[k % 6], 28'(k * 28'h111)};
            if (k == 2) out_ready = 1'b1;
            tick();
            if (k >= 2) begin
                n_cmp++;
                if (level !== 3'd2) begin n_err++; $display("FAIL wrap_level[%0d]: got %0d, required 2", k, level); end
            end
        end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_drain_timeout: got out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_invalid();
        logic [31:0] bad [3] = '{32'h3000_0000, 32'h8000_0000, 32'hbfff_ffff};
        logic [15:0] base;
        bit ok;
        base = inv_count;
        trap_cnt = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = bad[i];
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (inv_count !== base + 16'd3) begin n_err++; $display("FAIL inv_count: got %0d, required %0d", inv_count, base + 16'd3); end
        n_cmp++; if (trap_cnt !== (TRAP_EN ? 3 : 0)) begin n_err++; $display("FAIL trap_pulses: got %0d, required %0d", trap_cnt, TRAP_EN ? 3 : 0); end
        n_cmp++; if (level !== (TRAP_EN ? 3'd0 : 3'd3)) begin n_err++; $display("FAIL invalid_level: got %0d, required %0d", level, TRAP_EN ? 0 : 3); end
        drain(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL invalid_drain_timeout: got out_valid=%b, required 0", out_valid); end
    endtask

    task automatic test_saturate();
        logic [3:0] nibs [5] = '{4'h3, 4'h8, 4'h9, 4'ha, 4'hb};
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'b1;
            in_instr  = {nibs[i], 28'h0123456};
            tick();
            if (i == 1) begin
                n_cmp++;
                if (inv_count2 !== 2'd2) begin n_err++; $display("FAIL sat_mid: got %0d, required 2", inv_count2); end
            end
        end
        in_valid2 = 1'b0;
        tick();
        n_cmp++; if (inv_count2 !== 2'd3) begin n_err++; $display("FAIL sat_stick: got %0d, required 3", inv_count2); end
    endtask

    task automatic test_flush_reset();
        logic [15:0] cnt_before;
        cnt_before = inv_count;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_instr = 32'h1000_0a00 + 32'(i);
            tick();
        end
        n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL flush_pre_level: got %0d, required 3", level); end
        flush = 1'b1;
        out_ready = 1'b1;
        in_instr = 32'h0123_4567;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d, required 0", level); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
        n_cmp++; if (inv_count !== cnt_before) begin n_err++; $display("FAIL flush_keeps_count: got %0d, required %0d", inv_count, cnt_before); end
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_instr = 32'hd000_0000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_out_valid: got %b, required 0", out_valid); end
        n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL async_level: got %0d, required 0", level); end
        n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL async_out_instr: got %h, required 0", out_instr); end
        n_cmp++; if (out_kind !== KIND_INVALID) begin n_err++; $display("FAIL async_out_kind: got %0d, required %0d", out_kind, KIND_INVALID); end
        n_cmp++; if (inv_count !== 16'd0) begin n_err++; $display("FAIL async_inv_count: got %0d, required 0", inv_count); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_kinds();
        test_full();
        test_wrap();
        test_invalid();
        test_saturate();
        test_flush_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000ns");
        $fatal(1);
    end

endmodule
